// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter sharing one memory port between the CPU and a debug/loader port.
// Fixed memory read latency is absorbed internally; every access ends in a one-cycle ack.
module mem_port_arbiter #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   typedef enum logic {M_CPU, M_DBG} master_t;

   state_t        state_q, state_d;
   master_t       gnt_q, gnt_d;
   master_t       last_grant_q, last_grant_d;
   master_t       pick;
   logic          take;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dbg_ack_q, dbg_ack_d;

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      take         = 1'b0;
      pick         = M_CPU;

      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               take = 1'b1;
               if (cpu_req && dbg_req)
                  pick = (last_grant_q == M_CPU) ? M_DBG : M_CPU;
               else
                  pick = cpu_req ? M_CPU : M_DBG;
            end
         end
         ISSUE: begin
            // mem_we_q still holds the granted master's we during this cycle
            if (mem_we_q) begin
               state_d   = ACK;
               cpu_ack_d = (gnt_q == M_CPU);
               dbg_ack_d = (gnt_q == M_DBG);
            end else begin
               state_d = WAIT;
               cnt_d   = CW'(RD_LAT);
            end
         end
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               state_d   = ACK;
               cpu_ack_d = (gnt_q == M_CPU);
               dbg_ack_d = (gnt_q == M_DBG);
               if (gnt_q == M_CPU)
                  cpu_rdata_d = mem_rdata;
               else
                  dbg_rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACK: begin
            last_grant_d = gnt_q;
            state_d      = IDLE;
            // the just-acked master's req is ignored, so only the other one can win
            if (gnt_q == M_CPU && dbg_req) begin
               take = 1'b1;
               pick = M_DBG;
            end else if (gnt_q == M_DBG && cpu_req) begin
               take = 1'b1;
               pick = M_CPU;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d     = ISSUE;
         gnt_d       = pick;
         mem_en_d    = 1'b1;
         mem_we_d    = (pick == M_CPU) ? cpu_we    : dbg_we;
         mem_addr_d  = (pick == M_CPU) ? cpu_addr  : dbg_addr;
         mem_wdata_d = (pick == M_CPU) ? cpu_wdata : dbg_wdata;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= M_CPU;
         last_grant_q <= M_DBG;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with RD_LAT=2.
module tb_mem_port_arbiter;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned RD_LAT = 2;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic          cpu_ack, dbg_ack, mem_en, mem_we;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      mem_rdata = '0;
      #1 rst_n = 1'b0;
      step();
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      @(negedge clock) rst_n = 1'b1;

      // CPU read of 0x10; address input changes during WAIT must not reach memory
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      step(); // cycle 1
      chk("t1_c1_mem_en", mem_en, 1);
      chk("t1_c1_mem_we", mem_we, 0);
      chk("t1_c1_mem_addr", mem_addr, 32'h10);
      chk("t1_c1_cpu_ack", cpu_ack, 0);
      step(); // cycle 2
      chk("t1_c2_mem_en", mem_en, 0);
      chk("t1_c2_cpu_ack", cpu_ack, 0);
      cpu_addr = 32'h44;
      mem_rdata = 32'hBAD0_0002;
      step(); // cycle 3
      chk("t1_c3_mem_en", mem_en, 0);
      chk("t1_c3_mem_addr", mem_addr, 32'h10);
      chk("t1_c3_cpu_ack", cpu_ack, 0);
      mem_rdata = 32'hDEAD_BEEF;
      step(); // cycle 4
      chk("t1_c4_cpu_ack", cpu_ack, 1);
      chk("t1_c4_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("t1_c4_mem_addr", mem_addr, 32'h10);
      chk("t1_c4_mem_en", mem_en, 0);
      cpu_req = 1'b0;
      mem_rdata = 32'hBAD0_0004;
      step(); // cycle 5
      chk("t1_c5_cpu_ack", cpu_ack, 0);
      chk("t1_c5_cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

      // Debug write; rdata registers must not move even with live mem_rdata
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234;
      mem_rdata = 32'h5555_AAAA;
      step();
      chk("t2_c1_mem_en", mem_en, 1);
      chk("t2_c1_mem_we", mem_we, 1);
      chk("t2_c1_mem_addr", mem_addr, 32'h20);
      chk("t2_c1_mem_wdata", mem_wdata, 32'h1234);
      chk("t2_c1_dbg_ack", dbg_ack, 0);
      step();
      chk("t2_c2_dbg_ack", dbg_ack, 1);
      chk("t2_c2_cpu_ack", cpu_ack, 0);
      chk("t2_c2_mem_en", mem_en, 0);
      chk("t2_c2_mem_we", mem_we, 0);
      chk("t2_c2_dbg_rdata", dbg_rdata, 0);
      chk("t2_c2_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      dbg_req = 1'b0;
      step();
      chk("t2_c3_dbg_ack", dbg_ack, 0);

      // Fresh reset, then simultaneous writes: CPU wins the first tie
      rst_n = 1'b0;
      #1;
      chk("rst2_cpu_rdata", cpu_rdata, 0);
      chk("rst2_mem_wdata", mem_wdata, 0);
      @(negedge clock) rst_n = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hC0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hD0;
      step();
      chk("t3_c1_mem_en", mem_en, 1);
      chk("t3_c1_mem_addr", mem_addr, 32'h30);
      chk("t3_c1_mem_wdata", mem_wdata, 32'hC0);
      step();
      chk("t3_c2_cpu_ack", cpu_ack, 1);
      chk("t3_c2_dbg_ack", dbg_ack, 0);
      chk("t3_c2_mem_en", mem_en, 0);
      cpu_req = 1'b0;
      step();
      chk("t3_c3_mem_en", mem_en, 1);
      chk("t3_c3_mem_addr", mem_addr, 32'h40);
      chk("t3_c3_mem_wdata", mem_wdata, 32'hD0);
      chk("t3_c3_cpu_ack", cpu_ack, 0);
      step();
      chk("t3_c4_dbg_ack", dbg_ack, 1);
      chk("t3_c4_cpu_ack", cpu_ack, 0);
      dbg_req = 1'b0;
      step();
      chk("t3_c5_dbg_ack", dbg_ack, 0);

      // Both masters hold req for six writes: grants must alternate starting with CPU
      cpu_req = 1'b1; cpu_addr = 32'h100;
      dbg_req = 1'b1; dbg_addr = 32'h200;
      step();
      for (int i = 0; i < 6; i++) begin
         logic exp_cpu;
         exp_cpu = (i % 2 == 0);
         chk($sformatf("t4_issue%0d_mem_en", i), mem_en, 1);
         chk($sformatf("t4_issue%0d_mem_addr", i), mem_addr, exp_cpu ? 32'h100 : 32'h200);
         step();
         chk($sformatf("t4_ack%0d_cpu_ack", i), cpu_ack, {31'b0, exp_cpu});
         chk($sformatf("t4_ack%0d_dbg_ack", i), dbg_ack, {31'b0, ~exp_cpu});
         if (i == 5) begin
            cpu_req = 1'b0;
            dbg_req = 1'b0;
         end
         step();
      end
      chk("t4_idle_mem_en", mem_en, 0);

      // Reset during WAIT aborts the read; no ack ever follows
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
      step();
      chk("t6_c1_mem_en", mem_en, 1);
      step();
      chk("t6_c2_mem_en", mem_en, 0);
      #2 rst_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("t6_rst_mem_en", mem_en, 0);
      chk("t6_rst_mem_we", mem_we, 0);
      chk("t6_rst_cpu_ack", cpu_ack, 0);
      chk("t6_rst_dbg_ack", dbg_ack, 0);
      chk("t6_rst_mem_addr", mem_addr, 0);
      @(negedge clock) rst_n = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t6_quiet%0d_cpu_ack", i), cpu_ack, 0);
      end

      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h64;
      step();
      chk("t6r_c1_mem_en", mem_en, 1);
      chk("t6r_c1_mem_addr", mem_addr, 32'h64);
      step();
      chk("t6r_c2_cpu_ack", cpu_ack, 0);
      step();
      chk("t6r_c3_cpu_ack", cpu_ack, 0);
      mem_rdata = 32'hCAFE_F00D;
      step();
      chk("t6r_c4_cpu_ack", cpu_ack, 1);
      chk("t6r_c4_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
      cpu_req = 1'b0;
      mem_rdata = '0;
      step();
      chk("t6r_c5_cpu_ack", cpu_ack, 0);
      chk("t6r_c5_cpu_rdata_hold", cpu_rdata, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
